// File: rtl/cache_types.sv
// Shared cache-subsystem types: latched request kind plus arbiter state and grant encodings.
package cache_types;

  // Latched downstream operation.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_t;

  // Arbiter FSM state; plain constants keep older tools and dumps happy.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_BUSY_I = 2'd1;
  localparam arb_state_t ARB_BUSY_D = 2'd2;
  localparam arb_state_t ARB_DONE   = 2'd3;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Encode a requester's read/write strobes as a latched operation.
  function automatic req_t req_of(input logic rd, input logic wr);
    if (wr) return REQ_WRITE;
    if (rd) return REQ_READ;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/cache_arb_perf_cnt.sv
// Saturating event counter used for arbiter performance statistics.
module cache_arb_perf_cnt #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_dfp_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the I-cache and D-cache.
// A grant is held for the whole line transaction; request, response and data are registered.
// Optional build macro: CACHE_ARB_PERF_CNT_EN adds grant and conflict counters.
module cache_dfp_arbiter
  import cache_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [CNT_WIDTH-1:0]  perf_i_grants,
  output logic [CNT_WIDTH-1:0]  perf_d_grants,
  output logic [CNT_WIDTH-1:0]  perf_conflicts
);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q;
  req_t                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  i_resp_q, d_resp_q;
  logic                  i_req, d_req, grant_i, grant_d, busy;

  // Round-robin pick: on a tie the port that did not win last time goes first.
  always_comb begin
    i_req   = i_read | i_write;
    d_req   = d_read | d_write;
    grant_i = (state_q == ARB_IDLE) && i_req && (!d_req || (last_grant_q == GRANT_D));
    grant_d = (state_q == ARB_IDLE) && d_req && !grant_i;
    busy    = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  end

  // Next state: IDLE -> BUSY_x on grant, BUSY_x -> DONE on mem_resp, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_i)      state_d = ARB_BUSY_I;
        else if (grant_d) state_d = ARB_BUSY_D;
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_resp) state_d = ARB_DONE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Latch the granted request, capture the returned line and pulse the owner's resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_D;
      op_q         <= REQ_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        addr_q       <= i_addr;
        wdata_q      <= i_wdata;
        op_q         <= req_of(i_read, i_write);
        last_grant_q <= GRANT_I;
      end else if (grant_d) begin
        addr_q       <= d_addr;
        wdata_q      <= d_wdata;
        op_q         <= req_of(d_read, d_write);
        last_grant_q <= GRANT_D;
      end else if (busy && mem_resp) begin
        op_q    <= REQ_NONE;
        rdata_q <= mem_rdata;
      end
      i_resp_q <= (state_q == ARB_BUSY_I) && mem_resp;
      d_resp_q <= (state_q == ARB_BUSY_D) && mem_resp;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (op_q == REQ_READ);
  assign mem_write = (op_q == REQ_WRITE);
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;

`ifdef CACHE_ARB_PERF_CNT_EN
  logic conflict;

  // A waiting port counts every cycle: loser of an IDLE tie or non-owner while busy/done.
  always_comb begin
    conflict = 1'b0;
    if (state_q == ARB_IDLE)           conflict = i_req && d_req;
    else if (last_grant_q == GRANT_I)  conflict = d_req;
    else                               conflict = i_req;
  end

  cache_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_i (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_i),
    .count (perf_i_grants)
  );

  cache_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_d (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_d),
    .count (perf_d_grants)
  );

  cache_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_conflict (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (conflict),
    .count (perf_conflicts)
  );
`else
  assign perf_i_grants  = '0;
  assign perf_d_grants  = '0;
  assign perf_conflicts = '0;
`endif

`ifndef SYNTHESIS
  // Requester protocol and memory-side sanity.
  i_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(i_read && i_write));
  d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));
  i_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (i_req && !i_resp) |=> i_req);
  d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (d_req && !d_resp) |=> d_req);
  resp_in_busy: assert property (@(posedge clk) disable iff (!rst_n) mem_resp |-> busy);
`endif

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
module tb_cache_dfp_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;
  localparam logic [LW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_WD = {8{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
  logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [LW-1:0] i_wdata = '0, d_wdata = '0, i_rdata, d_rdata, mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [CW-1:0] perf_i_grants, perf_d_grants, perf_conflicts;

  cache_dfp_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
  );

  // Memory model: request is visible for lat cycles (lat >= 2), resp in the last of them.
  int            lat = 2;
  int            mcnt;
  logic [LW-1:0] rd_val = PAT_A5;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt      <= 0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= 1'b0;
      if ((mem_read || mem_write) && !mem_resp) begin
        if (mcnt >= lat - 2) begin
          mem_resp  <= 1'b1;
          mem_rdata <= rd_val;
          mcnt      <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;

  // Per-scenario observations.
  int            cyc, mr_cyc, mw_cyc, i_resp_n, d_resp_n, i_resp_at, d_resp_at, d_first;
  int            addr_flips, i_want, d_want;
  logic          i_drop, d_drop, prev_mr;
  logic [AW-1:0] prev_addr, waddr_seen, watch_addr;
  logic [LW-1:0] i_rd_seen, wdata_seen;
  string         glog;

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [LW-1:0] obs,
                           input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; mr_cyc = 0; mw_cyc = 0; i_resp_n = 0; d_resp_n = 0;
    i_resp_at = -1; d_resp_at = -1; d_first = -1; addr_flips = 0;
    prev_mr = 1'b0; prev_addr = '0; waddr_seen = '0; wdata_seen = '0; i_rd_seen = '0;
    glog = "";
  endtask

  // One clock: requesters drop one cycle after their resp and re-arm while they still
  // want more transactions; then the cycle's outputs are recorded.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (i_drop) begin
      i_read = 1'b0; i_write = 1'b0; i_drop = 1'b0;
    end else if (!i_read && !i_write && i_want > 0) begin
      i_read = 1'b1; i_want--;
    end
    if (d_drop) begin
      d_read = 1'b0; d_write = 1'b0; d_drop = 1'b0;
    end else if (!d_read && !d_write && d_want > 0) begin
      d_read = 1'b1; d_want--;
    end
    if (i_resp) i_drop = 1'b1;
    if (d_resp) d_drop = 1'b1;
    if (mem_read) mr_cyc++;
    if (mem_write) begin
      mw_cyc++; waddr_seen = mem_addr; wdata_seen = mem_wdata;
    end
    if (mem_read && prev_mr && (mem_addr !== prev_addr)) addr_flips++;
    prev_mr = mem_read; prev_addr = mem_addr;
    if (mem_read && (mem_addr == watch_addr) && (d_first < 0)) d_first = cyc;
    if (i_resp) begin
      i_resp_n++; i_rd_seen = i_rdata; glog = {glog, "I"};
      if (i_resp_at < 0) i_resp_at = cyc;
    end
    if (d_resp) begin
      d_resp_n++; glog = {glog, "D"};
      if (d_resp_at < 0) d_resp_at = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_drop = 1'b0; d_drop = 1'b0; i_want = 0; d_want = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    i_drop = 1'b0; d_drop = 1'b0; i_want = 0; d_want = 0; watch_addr = '1;
    clear_stats();

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_mem_read", int'(mem_read), 0);
    check_int("rst_mem_write", int'(mem_write), 0);
    check_int("rst_mem_addr", int'(mem_addr), 0);
    check_int("rst_resp", int'({i_resp, d_resp}), 0);
    check_vec("rst_i_rdata", i_rdata, '0);
    check_int("rst_perf", int'({perf_i_grants, perf_d_grants, perf_conflicts}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single I read, 5-cycle memory.
    tick();
    lat = 5; rd_val = PAT_A5;
    i_addr = 32'h0000_1040; i_read = 1'b1;
    clear_stats();
    tick();
    check_int("single_mem_read_n1", int'(mem_read), 1);
    check_int("single_mem_addr", int'(mem_addr), int'(32'h0000_1040));
    run(14);
    check_int("single_mem_read_cycles", mr_cyc, 5);
    check_int("single_i_resp_count", i_resp_n, 1);
    check_int("single_i_resp_cycle", i_resp_at, 6);
    check_vec("single_i_rdata", i_rd_seen, PAT_A5);
    check_int("single_d_resp_count", d_resp_n, 0);

    // Tie straight after reset: I first, then the D write.
    do_reset();
    tick();
    lat = 2;
    i_addr = 32'h0000_2000; i_read = 1'b1;
    d_addr = 32'h0000_3000; d_wdata = PAT_WD; d_write = 1'b1;
    clear_stats();
    run(20);
    check_str("tie_order", glog, "ID");
    check_int("tie_i_resp_cycle", i_resp_at, 3);
    check_int("tie_d_resp_cycle", d_resp_at, 7);
    check_int("tie_mem_write_cycles", mw_cyc, 2);
    check_int("tie_mem_write_addr", int'(waddr_seen), int'(32'h0000_3000));
    check_vec("tie_mem_wdata", wdata_seen, PAT_WD);

    // Sustained contention, six transactions.
    do_reset();
    tick();
    lat = 2;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    i_read = 1'b1; d_read = 1'b1; i_want = 2; d_want = 2;
    clear_stats();
    run(40);
    check_str("rr_order", glog, "IDIDID");
`ifdef CACHE_ARB_PERF_CNT_EN
    check_int("rr_perf_i", int'(perf_i_grants), 3);
    check_int("rr_perf_d", int'(perf_d_grants), 3);
    check_int("rr_perf_conflicts_nonzero", int'(perf_conflicts != '0), 1);
`else
    check_int("rr_perf_i", int'(perf_i_grants), 0);
    check_int("rr_perf_d", int'(perf_d_grants), 0);
    check_int("rr_perf_conflicts", int'(perf_conflicts), 0);
`endif

    // D request arriving while an I transaction is in flight.
    tick();
    lat = 4;
    i_addr = 32'h0000_4000; i_read = 1'b1;
    d_addr = 32'h0000_5000; watch_addr = 32'h0000_5000;
    clear_stats();
    run(2);
    d_read = 1'b1;
    run(18);
    check_int("arr_i_resp_cycle", i_resp_at, 5);
    check_int("arr_d_first_mem_cycle", d_first, 7);
    check_int("arr_d_resp_cycle", d_resp_at, 11);
    check_int("arr_addr_stable", addr_flips, 0);
    watch_addr = '1;

    // Reset during a D transaction.
    tick();
    lat = 8;
    d_addr = 32'h0000_7000; d_read = 1'b1;
    clear_stats();
    run(3);
    check_int("rmid_busy_read", int'(mem_read), 1);
    #2;
    rst_n = 1'b0;
    d_read = 1'b0; i_drop = 1'b0; d_drop = 1'b0;
    #1;
    check_int("rmid_mem_read_drop", int'(mem_read), 0);
    check_int("rmid_mem_write", int'(mem_write), 0);
    #10;
    check_int("rmid_no_resp", int'({i_resp, d_resp}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    lat = 2;
    i_addr = 32'h0000_6000; i_read = 1'b1;
    clear_stats();
    run(8);
    check_str("rmid_after_order", glog, "I");
    check_int("rmid_after_i_resp_cycle", i_resp_at, 3);
    check_int("rmid_after_mem_read_cycles", mr_cyc, 2);

    // Twenty I grants against a 4-bit counter.
    do_reset();
    tick();
    lat = 2;
    i_addr = 32'h0000_8000; i_read = 1'b1; i_want = 19;
    clear_stats();
    run(150);
    check_int("sat_i_resp_count", i_resp_n, 20);
`ifdef CACHE_ARB_PERF_CNT_EN
    check_int("sat_perf_i", int'(perf_i_grants), 15);
`else
    check_int("sat_perf_i", int'(perf_i_grants), 0);
`endif
    check_int("sat_perf_d", int'(perf_d_grants), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
